// File: rtl/mem_responder.sv
// Byte RAM plus LED/STATUS/timer registers, with a streaming loader that holds the CPU in reset while it fills RAM.
// Optional 8-bit timer is built when MEM_TIMER_EN is defined; otherwise its registers read as zero.

module mem_responder #(
    parameter int ADDR_BITS = 12,
    parameter int PRESCALE  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  di,
    output logic [7:0]  do_o,      // `do` is a reserved word, hence the suffix
    input  logic        we,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic        ld_end,
    input  logic [7:0]  ld_data,
    output logic        cpu_rst,
    output logic [7:0]  led,
    output logic        dbg_load
);

    localparam logic [16:0] DEPTH    = 17'd1 << ADDR_BITS;
    localparam logic [15:0] A_LED    = 16'hFF00;
    localparam logic [15:0] A_STATUS = 16'hFF01;
    localparam logic [15:0] A_CMP    = 16'hFF02;
    localparam logic [15:0] A_CNT    = 16'hFF03;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic                 ovf_q, ovf_d;
    logic                 cpu_rst_q;
    logic                 ld_we;
    logic [7:0]           led_q, led_d;

    logic [7:0]           mem [0:(1<<ADDR_BITS)-1];
    logic [7:0]           ram_rd_q;
    logic                 ram_sel_q;
    logic [7:0]           reg_rd_q, reg_rd_d;

    logic                 in_load, bus_we, is_ram;
    logic                 sel_led, sel_status, sel_cmp, sel_cnt;
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 ram_we;
    logic [ADDR_BITS-1:0] ram_waddr;
    logic [7:0]           ram_wdata;

    logic                 timer_flag;
    logic [7:0]           cmp_rd, cnt_rd;

    assign in_load    = (state_q == LOAD);
    assign bus_we     = we & ~in_load;
    assign is_ram     = ({1'b0, addr} < DEPTH);
    assign ram_idx    = addr[ADDR_BITS-1:0];
    assign sel_led    = (addr == A_LED);
    assign sel_status = (addr == A_STATUS);
    assign sel_cmp    = (addr == A_CMP);
    assign sel_cnt    = (addr == A_CNT);

    // Loader next-state: ld_start always restarts; a final byte with ld_end is written first.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        ld_we   = 1'b0;
        if (bus_we && sel_status && di[1]) begin
            ovf_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    if (ld_valid) begin
                        ld_we = 1'b1;
                        ptr_d = ptr_q + 1'b1;
                        if (&ptr_q) begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (ld_end) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ovf_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ovf_q     <= ovf_d;
            cpu_rst_q <= (state_d == LOAD);
        end
    end

    // Single write port shared by loader and bus; the two are never active together.
    assign ram_we    = rst & (ld_we | (bus_we & is_ram));
    assign ram_waddr = in_load ? ptr_q : ram_idx;
    assign ram_wdata = in_load ? ld_data : di;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rd_q <= mem[ram_idx];
    end

`ifdef MEM_TIMER_EN
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    cmp_q, cmp_d;
    logic          flag_q, flag_d;
    logic          tick;

    always_comb begin
        tick   = (pre_q == PW'(PRESCALE - 1));
        pre_d  = tick ? '0 : pre_q + 1'b1;
        cnt_d  = cnt_q + {7'd0, tick};
        cmp_d  = (bus_we && sel_cmp) ? di : cmp_q;
        flag_d = flag_q;
        if (bus_we && sel_status && di[0]) begin
            flag_d = 1'b0;
        end
        if (tick && (cnt_d == cmp_q)) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            cnt_q  <= 8'h00;
            cmp_q  <= 8'hFF;
            flag_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            cmp_q  <= cmp_d;
            flag_q <= flag_d;
        end
    end

    assign timer_flag = flag_q;
    assign cmp_rd     = cmp_q;
    assign cnt_rd     = cnt_q;
`else
    assign timer_flag = 1'b0;
    assign cmp_rd     = 8'h00;
    assign cnt_rd     = 8'h00;
`endif

    assign led_d = (bus_we && sel_led) ? di : led_q;

    always_comb begin
        reg_rd_d = 8'h00;
        if (!in_load && !is_ram) begin
            if (sel_led) begin
                reg_rd_d = led_q;
            end else if (sel_status) begin
                reg_rd_d = {6'd0, ovf_q, timer_flag};
            end else if (sel_cmp) begin
                reg_rd_d = cmp_rd;
            end else if (sel_cnt) begin
                reg_rd_d = cnt_rd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q     <= 8'h00;
            reg_rd_q  <= 8'h00;
            ram_sel_q <= 1'b0;
        end else begin
            led_q     <= led_d;
            reg_rd_q  <= reg_rd_d;
            ram_sel_q <= ~in_load & is_ram;
        end
    end

    assign do_o     = ram_sel_q ? ram_rd_q : reg_rd_q;
    assign led      = led_q;
    assign cpu_rst  = cpu_rst_q;
    assign dbg_load = in_load;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 12, giving the RAM depth of 2^ADDR_BITS bytes mapped at 0x0000.
REQ-002 The block SHALL have parameter PRESCALE, default 256, giving clk cycles per timer tick (minimum 2).
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-005 The block SHALL have port addr  input  16  bus address from the CPU.
REQ-006 The block SHALL have port di  input  8  write data from the CPU.
REQ-007 The block SHALL have port do  output  8  registered read data to the CPU.
REQ-008 The block SHALL have port we  input  1  bus write strobe, active-high.
REQ-009 The block SHALL have ports ld_start, ld_valid, ld_end  input  1 each, and ld_data  input  8, forming the loader port.
REQ-010 The block SHALL have ports cpu_rst  output  1  (CPU hold, active-high) and led  output  8  (LED register).

Function
REQ-011 Reads SHALL have 1-cycle latency: do at edge N+1 reflects the location addressed at edge N, every cycle, with no read enable.
REQ-012 Writes SHALL occur at the rising edge where we=1; a same-address read in that cycle SHALL return old data (read-first).
REQ-013 Decode SHALL be: addr < 2^ADDR_BITS RAM; 0xFF00 LED (R/W); 0xFF01 STATUS (bit0 timer flag, bit1 load overflow); 0xFF02 TIMER_CMP (R/W); 0xFF03 TIMER_CNT (RO).
REQ-014 Unmapped addresses SHALL read 0x00 and ignore writes; writes to TIMER_CNT SHALL be ignored.
REQ-015 The loader FSM SHALL have states IDLE and LOAD; ld_start in IDLE SHALL enter LOAD and clear pointer to 0 and STATUS bit1.
REQ-016 In LOAD, each cycle with ld_valid=1 SHALL write ld_data to RAM[pointer] and increment the pointer.
REQ-017 The pointer SHALL wrap from 2^ADDR_BITS-1 to 0 and set sticky STATUS bit1.
REQ-018 ld_end in LOAD SHALL return to IDLE; if ld_valid is also high, that byte SHALL be written first.
REQ-019 ld_start in LOAD SHALL restart at pointer 0.
REQ-020 ld_valid and ld_end in IDLE SHALL be ignored.
REQ-021 cpu_rst SHALL be 1 exactly while in LOAD, registered from state.
REQ-022 In LOAD, bus writes SHALL be ignored and do SHALL read 0x00.
REQ-023 Writing STATUS with bit0=1 SHALL clear the timer flag, and with bit1=1 SHALL clear the overflow bit.
REQ-024 If a flag set and a clear occur in the same cycle, the set SHALL win.

Reset
REQ-025 While rst=0: do=0x00, led=0x00, state=IDLE, pointer=0, STATUS=0, TIMER_CNT=0, TIMER_CMP=0xFF, prescaler=0, cpu_rst=1.
REQ-026 After rst deassertion, cpu_rst SHALL drop to 0 on the first clk edge.
REQ-027 RAM contents SHALL NOT be altered by reset.
REQ-028 Reset mid-LOAD SHALL abort to IDLE, and bytes already written SHALL remain.

Configuration
REQ-029 With macro MEM_TIMER_EN defined, the timer SHALL be built: the prescaler counts 0..PRESCALE-1; on wrap TIMER_CNT increments (8-bit, 0xFF->0x00); if the new TIMER_CNT equals TIMER_CMP, STATUS bit0 SHALL set.
REQ-030 Without MEM_TIMER_EN, no timer logic SHALL exist: 0xFF02 and 0xFF03 read 0x00, writes are ignored, and STATUS bit0 reads 0.

Verification
REQ-031 Bench SHALL cover write: we=1, addr=0x0010, di=0xA5, then read 0x0010 -> do=0xA5 one cycle after the address.
REQ-032 Bench SHALL cover load: ld_start, then 4 ld_valid bytes 0x11,0x22,0x33,0x44, then ld_end -> cpu_rst=1 throughout; RAM[0..3]=those bytes; cpu_rst=0 after.
REQ-033 Bench SHALL cover overflow: ADDR_BITS=4, load 17 bytes -> RAM[0]=byte 17 and STATUS=0x02; write 0x02 to 0xFF01 -> STATUS=0x00.
REQ-034 Bench SHALL cover timer (MEM_TIMER_EN, PRESCALE=2, CMP=0x03): after 6 cycles CNT=0x03 and STATUS bit0=1; a clear coincident with a set leaves it 1.
REQ-035 Bench SHALL cover misc bus: write 0x5A to 0xFF00 -> led=0x5A; read 0x8000 -> 0x00; assert rst=0 mid-LOAD -> cpu_rst=1, state IDLE after release.
